// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator and its consumers.
// The frame_irq/irq_ack pair exists only when VGA_FRAME_IRQ_EN is defined.
interface vga_timing_gen_if #(
    parameter int COUNT_WIDTH = 10
);
    logic                   pixel_tick;
    logic                   hsync;
    logic                   vsync;
    logic                   display_en;
    logic [COUNT_WIDTH-1:0] x;
    logic [COUNT_WIDTH-1:0] y;
    logic                   line_start;
    logic                   frame_start;
`ifdef VGA_FRAME_IRQ_EN
    logic                   frame_irq;
    logic                   irq_ack;
`endif

    modport master (
        input  pixel_tick,
        output hsync,
        output vsync,
        output display_en,
        output x,
        output y,
        output line_start,
        output frame_start
`ifdef VGA_FRAME_IRQ_EN
        ,
        output frame_irq,
        input  irq_ack
`endif
    );

    modport slave (
        output pixel_tick,
        input  hsync,
        input  vsync,
        input  display_en,
        input  x,
        input  y,
        input  line_start,
        input  frame_start
`ifdef VGA_FRAME_IRQ_EN
        ,
        input  frame_irq,
        output irq_ack
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: hsync/vsync, display enable, pixel coordinates and line/frame strobes.
// Optional vblank interrupt (frame_irq/irq_ack) is enabled by defining VGA_FRAME_IRQ_EN.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int COUNT_WIDTH = 10
) (
    input logic               clk,
    input logic               rst,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNT_WIDTH-1:0] H_LAST     = COUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] H_FRONT_AT = COUNT_WIDTH'(H_VISIBLE);
    localparam logic [COUNT_WIDTH-1:0] H_SYNC_AT  = COUNT_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COUNT_WIDTH-1:0] H_BACK_AT  = COUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COUNT_WIDTH-1:0] V_LAST     = COUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] V_FRONT_AT = COUNT_WIDTH'(V_VISIBLE);
    localparam logic [COUNT_WIDTH-1:0] V_SYNC_AT  = COUNT_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COUNT_WIDTH-1:0] V_BACK_AT  = COUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        PH_VISIBLE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    // A phase moves on only when the freshly advanced count lands on the next phase's first value.
    function automatic phase_e next_phase(
        input phase_e                 cur,
        input logic [COUNT_WIDTH-1:0] nxt,
        input logic [COUNT_WIDTH-1:0] front_at,
        input logic [COUNT_WIDTH-1:0] sync_at,
        input logic [COUNT_WIDTH-1:0] back_at
    );
        next_phase = cur;
        case (cur)
            PH_VISIBLE: if (nxt == front_at) next_phase = PH_FRONT;
            PH_FRONT:   if (nxt == sync_at)  next_phase = PH_SYNC;
            PH_SYNC:    if (nxt == back_at)  next_phase = PH_BACK;
            PH_BACK:    if (nxt == '0)       next_phase = PH_VISIBLE;
        endcase
    endfunction

    logic                   tick_q, tick_d;
    logic [COUNT_WIDTH-1:0] h_count_q, h_count_d;
    logic [COUNT_WIDTH-1:0] v_count_q, v_count_d;
    phase_e                 h_phase_q, h_phase_d;
    phase_e                 v_phase_q, v_phase_d;
    logic                   line_pend_q, line_pend_d;
    logic                   frame_pend_q, frame_pend_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   display_en_q, display_en_d;
    logic [COUNT_WIDTH-1:0] x_q, x_d;
    logic [COUNT_WIDTH-1:0] y_q, y_d;
    logic                   line_start_q, line_start_d;
    logic                   frame_start_q, frame_start_d;
    logic                   adv;
    logic                   h_wrap;
    logic                   v_wrap;
`ifdef VGA_FRAME_IRQ_EN
    logic                   frame_irq_q, frame_irq_d;
`endif

    always_comb begin
        tick_d       = vga.pixel_tick;
        adv          = vga.pixel_tick & ~tick_q;
        h_wrap       = adv && (h_count_q == H_LAST);
        v_wrap       = h_wrap && (v_count_q == V_LAST);

        h_count_d    = h_count_q;
        v_count_d    = v_count_q;
        h_phase_d    = h_phase_q;
        v_phase_d    = v_phase_q;

        if (adv) begin
            h_count_d = h_wrap ? '0 : h_count_q + COUNT_WIDTH'(1);
            h_phase_d = next_phase(h_phase_q, h_count_d, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
        end
        if (h_wrap) begin
            v_count_d = v_wrap ? '0 : v_count_q + COUNT_WIDTH'(1);
            v_phase_d = next_phase(v_phase_q, v_count_d, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
        end

        line_pend_d  = h_wrap;
        frame_pend_d = v_wrap;

        // Output stage samples the counters one clk after they advance.
        x_d           = h_count_q;
        y_d           = v_count_q;
        display_en_d  = (h_phase_q == PH_VISIBLE) && (v_phase_q == PH_VISIBLE);
        hsync_d       = (h_phase_q == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = (v_phase_q == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
        line_start_d  = line_pend_q;
        frame_start_d = frame_pend_q;

`ifdef VGA_FRAME_IRQ_EN
        frame_irq_d = frame_irq_q;
        if (vga.irq_ack) frame_irq_d = 1'b0;
        if (h_wrap && (v_phase_q == PH_VISIBLE) && (v_phase_d == PH_FRONT)) frame_irq_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q        <= 1'b0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            h_phase_q     <= PH_VISIBLE;
            v_phase_q     <= PH_VISIBLE;
            line_pend_q   <= 1'b0;
            frame_pend_q  <= 1'b0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            display_en_q  <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_IRQ_EN
            frame_irq_q   <= 1'b0;
`endif
        end else begin
            tick_q        <= tick_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            h_phase_q     <= h_phase_d;
            v_phase_q     <= v_phase_d;
            line_pend_q   <= line_pend_d;
            frame_pend_q  <= frame_pend_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_en_q  <= display_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_IRQ_EN
            frame_irq_q   <= frame_irq_d;
`endif
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.display_en  = display_en_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
`ifdef VGA_FRAME_IRQ_EN
    assign vga.frame_irq   = frame_irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster so whole frames fit in a short run.
// Reference model counts advances since reset and derives every output from that count arithmetically.
module tb_vga_timing_gen;

    localparam int CW    = 10;
    localparam int HV    = 20;
    localparam int HF    = 4;
    localparam int HS    = 6;
    localparam int HB    = 5;
    localparam int VV    = 12;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COUNT_WIDTH(CW)) vga ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vga)
    );

    int errors = 0;
    int checks = 0;

    int adv_n     = 0;
    bit prev_tick = 1'b0;
    int out_n     = 0;
    int prev_out  = 0;
    bit out_reset = 1'b1;
    bit exp_irq   = 1'b0;

    typedef struct {
        bit rst;
        bit tick;
        int x;
        int de;
        int hs;
        int ls;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one clk of inputs and advance the reference model across that edge.
    task automatic applyStimulus(input bit r, input bit tick, input bit ack);
        bit set_irq;
        rst = r;
        vga.pixel_tick = tick;
`ifdef VGA_FRAME_IRQ_EN
        vga.irq_ack = ack;
`endif
        @(posedge clk);
        set_irq = 1'b0;
        if (!r) begin
            adv_n     = 0;
            prev_tick = 1'b0;
            out_n     = 0;
            prev_out  = 0;
            out_reset = 1'b1;
            exp_irq   = 1'b0;
        end else begin
            prev_out  = out_n;
            out_n     = adv_n;
            out_reset = 1'b0;
            if (tick && !prev_tick) begin
                adv_n++;
                if ((adv_n % HT == 0) && ((adv_n / HT) % VT == VV)) set_irq = 1'b1;
            end
            if (ack) exp_irq = 1'b0;
            if (set_irq) exp_irq = 1'b1;
            prev_tick = tick;
        end
        #1;
    endtask

    task automatic checkModel();
        int h;
        int v;
        bit moved;
        h     = out_n % HT;
        v     = (out_n / HT) % VT;
        moved = !out_reset && (out_n != prev_out);
        checkOutput("x", 32'(vga.x), h);
        checkOutput("y", 32'(vga.y), v);
        checkOutput("display_en", 32'(vga.display_en), (!out_reset && h < HV && v < VV) ? 1 : 0);
        checkOutput("hsync", 32'(vga.hsync), (!out_reset && h >= HV + HF && h < HV + HF + HS) ? 0 : 1);
        checkOutput("vsync", 32'(vga.vsync), (!out_reset && v >= VV + VF && v < VV + VF + VS) ? 0 : 1);
        checkOutput("line_start", 32'(vga.line_start), (moved && h == 0) ? 1 : 0);
        checkOutput("frame_start", 32'(vga.frame_start), (moved && h == 0 && v == 0) ? 1 : 0);
`ifdef VGA_FRAME_IRQ_EN
        checkOutput("frame_irq", 32'(vga.frame_irq), 32'(exp_irq));
`endif
    endtask

    task automatic step(input bit r, input bit tick, input bit ack);
        applyStimulus(r, tick, ack);
        checkModel();
    endtask

    initial begin
        vec_t vecs[9];
        bit   vs_seen[VT];
        int   hold_x;
        int   vs_lines;
        bit   found;
        bit   t;

        vecs[0] = '{rst: 1'b0, tick: 1'b1, x: 0, de: 0, hs: 1, ls: 0};
        vecs[1] = '{rst: 1'b1, tick: 1'b1, x: 0, de: 1, hs: 1, ls: 0};
        vecs[2] = '{rst: 1'b1, tick: 1'b1, x: 1, de: 1, hs: 1, ls: 0};
        vecs[3] = '{rst: 1'b1, tick: 1'b0, x: 1, de: 1, hs: 1, ls: 0};
        vecs[4] = '{rst: 1'b1, tick: 1'b1, x: 1, de: 1, hs: 1, ls: 0};
        vecs[5] = '{rst: 1'b1, tick: 1'b0, x: 2, de: 1, hs: 1, ls: 0};
        vecs[6] = '{rst: 1'b1, tick: 1'b0, x: 2, de: 1, hs: 1, ls: 0};
        vecs[7] = '{rst: 1'b1, tick: 1'b1, x: 2, de: 1, hs: 1, ls: 0};
        vecs[8] = '{rst: 1'b1, tick: 1'b0, x: 3, de: 1, hs: 1, ls: 0};

        vga.pixel_tick = 1'b0;
`ifdef VGA_FRAME_IRQ_EN
        vga.irq_ack = 1'b0;
`endif

        // Reset held while the tick toggles at clk/4.
        for (int i = 0; i < 4; i++) step(1'b0, (i % 4) < 2, 1'b0);
        checkOutput("reset_vsync", 32'(vga.vsync), 1);

        // Table of constant vectors covering reset release and the first advances.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].tick, 1'b0);
            checkOutput($sformatf("vec%0d_x", i), 32'(vga.x), vecs[i].x);
            checkOutput($sformatf("vec%0d_de", i), 32'(vga.display_en), vecs[i].de);
            checkOutput($sformatf("vec%0d_hs", i), 32'(vga.hsync), vecs[i].hs);
            checkOutput($sformatf("vec%0d_ls", i), 32'(vga.line_start), vecs[i].ls);
        end

        // clk/4 tick for more than a line: crosses every h phase and the first line wrap.
        for (int i = 0; i < HT + 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end

        // Tick stuck high mid-line freezes everything; the next rising edge advances by one.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        hold_x = out_n % HT;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checkOutput("hold_x", 32'(vga.x), hold_x);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checkOutput("after_hold_x", 32'(vga.x), (hold_x + 1) % HT);

        // Randomised run over two full frames with occasional acks.
        for (int i = 0; i < VT; i++) vs_seen[i] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            t = ($urandom_range(0, 2) != 0) ? ~vga.pixel_tick : vga.pixel_tick;
            step(1'b1, t, $urandom_range(0, 15) == 0);
            if (vga.vsync === 1'b0 && int'(vga.y) < VT) vs_seen[int'(vga.y)] = 1'b1;
            if (adv_n >= 2 * FRAME + 40) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("random_run_done", 32'(found), 1);
        vs_lines = 0;
        for (int i = 0; i < VT; i++) vs_lines += vs_seen[i];
        checkOutput("vsync_line_count", vs_lines, VS);
        checkOutput("vsync_first_line", 32'(vs_seen[VV + VF]), 1);
        checkOutput("vsync_last_line", 32'(vs_seen[VV + VF + VS - 1]), 1);

        // Reset while hsync is active: everything returns to idle with no leftover pulse.
        found = 1'b0;
        for (int i = 0; i < 4 * HT; i++) begin
            step(1'b1, ~vga.pixel_tick, 1'b0);
            if ((out_n % HT) >= HV + HF + 2 && (out_n % HT) < HV + HF + HS) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached_hsync", 32'(found), 1);
        checkOutput("pre_reset_hsync", 32'(vga.hsync), 0);
        applyStimulus(1'b0, ~vga.pixel_tick, 1'b0);
        checkOutput("rst_x", 32'(vga.x), 0);
        checkOutput("rst_y", 32'(vga.y), 0);
        checkOutput("rst_hsync", 32'(vga.hsync), 1);
        checkOutput("rst_line_start", 32'(vga.line_start), 0);
        checkOutput("rst_display_en", 32'(vga.display_en), 0);
        for (int i = 0; i < 3 * HT; i++) step(1'b1, ~vga.pixel_tick, 1'b0);

`ifdef VGA_FRAME_IRQ_EN
        // Ack in the set clk loses to the set; an ack one clk later clears.
        step(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (((adv_n + 1) % HT == 0) && (((adv_n + 1) / HT) % VT == VV)) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b1);
        end
        checkOutput("irq_reached", 32'(found), 1);
        step(1'b1, 1'b1, 1'b1);
        checkOutput("irq_set_wins", 32'(vga.frame_irq), 1);
        step(1'b1, 1'b0, 1'b0);
        checkOutput("irq_held", 32'(vga.frame_irq), 1);
        step(1'b1, 1'b0, 1'b1);
        checkOutput("irq_acked", 32'(vga.frame_irq), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
